// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the 4-register datapath write-back side.
//
// Contents:
//   DATA_W      default register / data width
//   REG_A..D    register select encodings carried on wr_sel
//   wb_entry_t  one queued write: target register select plus data
package cpu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;
    localparam logic [1:0] REG_C = 2'd2;
    localparam logic [1:0] REG_D = 2'd3;

    typedef struct packed {
        logic [1:0]        sel;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- synchronous FIFO of wb_entry_t used as the write-back queue.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; empties the queue
//   push       write din at the tail (ignored when full)
//   pop        drop the head entry (ignored when empty)
//   din        entry to enqueue
//   full       count == DEPTH
//   empty      count == 0
//   count      number of valid entries, log2(DEPTH)+1 bits
//   head       entry at the read pointer
//   valid_vec  per-slot occupancy
//   sel_vec    per-slot register select, meaningful where valid_vec is set
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  wb_entry_t                 din,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output wb_entry_t                 head,
    output logic [DEPTH-1:0]          valid_vec,
    output logic [DEPTH-1:0][1:0]     sel_vec
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    wb_entry_t        mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_vec <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr            <= wr_ptr + 1'b1;
                valid_vec[wr_ptr] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr            <= rd_ptr + 1'b1;
                valid_vec[rd_ptr] <= 1'b0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; valid_vec and count decide which
    // slots are meaningful, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel_vec[i] = mem[i].sel;
        end
    end

endmodule

// File: rtl/reg_demux4_wb.sv
// reg_demux4_wb -- write-back side of the 4-register datapath.
// Results are queued in wb_fifo and drained one per cycle into register
// A/B/C/D; pend exposes which registers still have queued writes.
//
// Build option: define WB_BYPASS_EN to write straight into the bank when the
// queue is empty and hold=0 (one-edge latency, no pend). Default: every write
// goes through the queue (two-edge latency).
//
// Parameters:
//   DATA_W    register / data width (must match cpu_pkg::DATA_W)
//   DEPTH     write-queue entries (power of two, >= 2)
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   Win       write data
//   wr_sel    target register: 0=A 1=B 2=C 3=D
//   wr_valid  write request
//   wr_ready  queue can accept (rst_n & count<DEPTH)
//   hold      freeze the register bank and queue head
//   Aout..Dout register contents
//   pend      bit i set while a queued entry targets register i
//   busy      queue non-empty
module reg_demux4_wb
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] Win,
    input  logic [1:0]        wr_sel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              hold,
    output logic [DATA_W-1:0] Aout,
    output logic [DATA_W-1:0] Bout,
    output logic [DATA_W-1:0] Cout,
    output logic [DATA_W-1:0] Dout,
    output logic [3:0]        pend,
    output logic              busy
);

    localparam int             CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic                    full;
    logic                    empty;
    logic [CNT_W-1:0]        count;
    wb_entry_t               head;
    wb_entry_t               din;
    logic [DEPTH-1:0]        valid_vec;
    logic [DEPTH-1:0][1:0]   sel_vec;
    logic                    accept;
    logic                    bypass;
    logic                    push;
    logic                    pop;
    logic [3:0]              we;
    logic [DATA_W-1:0]       wdata;
    logic [DATA_W-1:0]       regs [4];

    assign wr_ready = rst_n & (count < DEPTH_C);
    assign accept   = wr_valid & wr_ready;
    assign din      = '{sel: wr_sel, data: Win};

`ifdef WB_BYPASS_EN
    // Empty queue and an unfrozen bank: skip the queue entirely.
    assign bypass = accept & empty & ~hold;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~bypass;
    assign pop  = ~hold & ~empty;
    assign busy = ~empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head),
        .valid_vec (valid_vec),
        .sel_vec   (sel_vec)
    );

    // 2->4 write decode. A drain and a bypass never coincide: bypass needs an
    // empty queue, drain a non-empty one.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        we    = 4'b0000;
        wdata = head.data;
        if (pop) begin
            we[head.sel] = 1'b1;
        end else if (bypass) begin
            we[wr_sel] = 1'b1;
            wdata      = Win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        pend = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_vec[i]) begin
                pend[sel_vec[i]] = 1'b1;
            end
        end
    end

    assign Aout = regs[REG_A];
    assign Bout = regs[REG_B];
    assign Cout = regs[REG_C];
    assign Dout = regs[REG_D];

endmodule
